// File: rtl/serial_adder_nb.sv
// serial_adder_nb: digit-serial adder. Operands are latched on start and
// added DIGIT bits per clock, least significant digit first, through a
// registered carry. The full WIDTH+1 bit result appears in s when done
// pulses and is held until the next result is written.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that
// selects a - b (computed as a + ~b + 1, cin ignored).
module serial_adder_nb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   s
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH:0]   s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_sum;
    int               lo;

    // Digit adder: current digit of both latched operands plus carry.
    always_comb begin
        lo      = int'(cnt_q) * DIGIT;
        dig_a   = a_q[lo +: DIGIT];
        dig_b   = b_q[lo +: DIGIT];
        dig_sum = (DIGIT+1)'(dig_a) + (DIGIT+1)'(dig_b) + (DIGIT+1)'(c_q);
    end

    // Next-state logic: operand capture, digit accumulation, result load.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        s_d     = s_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    c_d    = cin;
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub) begin
                        b_d = ~b;
                        c_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                psum_d[lo +: DIGIT] = dig_sum[DIGIT-1:0];
                c_d                 = dig_sum[DIGIT];
                cnt_d               = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d     = {dig_sum[DIGIT], psum_d};
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;

endmodule

// File: tb/tb_serial_adder_nb.sv
// tb_serial_adder_nb: directed vectors for serial_adder_nb (WIDTH=8 with
// DIGIT=2 and DIGIT=8). Expected sums are pushed when a start is issued;
// monitors pop and compare whenever done is seen.
module tb_serial_adder_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done;
    logic [8:0] s;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8;
    logic [8:0] s8;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
    logic       sub8 = 1'b0;
`endif

    logic [8:0] exp_q[$];
    logic [8:0] exp8_q[$];
    int n_cmp = 0;
    int n_err = 0;

    serial_adder_nb #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .s(s)
    );

    serial_adder_nb #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .s(s8)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl", 32'(busy & done), 0);
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 32'(done), 0);
                else check("result", 32'(s), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl8", 32'(busy8 & done8), 0);
            if (done8) begin
                if (exp8_q.size() == 0) check("unexpected_done8", 32'(done8), 0);
                else check("result8", 32'(s8), 32'(exp8_q.pop_front()));
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                         input logic [8:0] exp);
        a     = ia;
        b     = ib;
        cin   = icin;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        start = 1'b1;
        exp_q.push_back(exp);
    endtask

    // Waits for done, counting busy cycles; returns at the done negedge.
    task automatic wait_done(input bit drop_start, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (drop_start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        if (!seen) check("done_timeout", 32'(done), 1);
    endtask

    task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                      input logic [8:0] exp);
        int bc;
        @(negedge clk);
        issue(ia, ib, icin, exp);
        wait_done(1'b1, bc);
        check("busy_cycles", 32'(bc), 4);
    endtask

    initial begin
        int  bc;
        bit  seen;

        // reset state
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_s", 32'(s), 0);
        check("rst_s8", 32'(s8), 0);

        // first start right after reset release
        @(negedge clk);
        rst = 1'b0;
        issue(8'hFF, 8'h01, 1'b0, 9'h100);
        wait_done(1'b1, bc);
        check("busy_cycles_ff01", 32'(bc), 4);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("s_held_idle", 32'(s), 32'h100);

        // start held through RUN, operands wiggled mid-operation
        @(negedge clk);
        issue(8'h5A, 8'h3C, 1'b1, 9'h097);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                seen  = 1'b1;
                break;
            end
            if (busy) begin
                a   = 8'($urandom_range(0, 255));
                b   = 8'($urandom_range(0, 255));
                cin = ~cin;
            end
        end
        if (!seen) check("done_timeout_held", 32'(done), 1);
        repeat (6) begin
            @(negedge clk);
            check("no_extra_op", 32'(busy), 0);
        end
        check("queue_drained_held", 32'(exp_q.size()), 0);

        // back-to-back: new start in the DONE cycle
        @(negedge clk);
        issue(8'h12, 8'h34, 1'b0, 9'h046);
        wait_done(1'b1, bc);
        issue(8'h80, 8'h80, 1'b0, 9'h100);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_s_held", 32'(s), 32'h046);
        wait_done(1'b0, bc);
        check("b2b_busy_rest", 32'(bc), 3);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_s", 32'(s), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abandoned_no_done", 32'(done), 0);
        end
        check("abandoned_s", 32'(s), 0);

        // assorted directed sums
        op(8'h00, 8'h00, 1'b0, 9'h000);
        op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op(8'hA5, 8'h5A, 1'b1, 9'h100);
        op(8'h01, 8'h7F, 1'b0, 9'h080);

`ifdef SERIAL_ADDER_SUB_EN
        // subtraction: cin ignored, s[8] is the no-borrow flag
        @(negedge clk);
        issue(8'h05, 8'h07, 1'b1, 9'h0FE);
        sub = 1'b1;
        wait_done(1'b1, bc);
        sub = 1'b0;
        @(negedge clk);
        issue(8'h07, 8'h05, 1'b0, 9'h102);
        sub = 1'b1;
        wait_done(1'b1, bc);
        sub = 1'b0;
        op(8'h07, 8'h05, 1'b0, 9'h00C);
`endif

        // DIGIT = WIDTH: a single RUN cycle
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a8     = (k == 0) ? 8'hF0 : 8'hFF;
            b8     = (k == 0) ? 8'h0F : 8'hFF;
            cin8   = (k == 0);
            exp8_q.push_back((k == 0) ? 9'h100 : 9'h1FE);
            start8 = 1'b1;
            bc     = 0;
            seen   = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                start8 = 1'b0;
                if (done8) begin
                    seen = 1'b1;
                    break;
                end
                if (busy8) bc++;
            end
            if (!seen) check("done8_timeout", 32'(done8), 1);
            check("busy8_cycles", 32'(bc), 1);
        end

        // final report
        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 0);
        check("exp8_q_empty", 32'(exp8_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_nb.md
SERIAL_ADDER_NB -- requirements
Module: serial_adder_nb

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 2, bits added per cycle; SHALL divide WIDTH exactly; DIGIT = WIDTH is legal.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 a  input  WIDTH  operand A, [MSB:LSB].
REQ-007 b  input  WIDTH  operand B, [MSB:LSB].
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; s is valid from this cycle on.
REQ-011 s  output  WIDTH+1  result; s[WIDTH] = carry-out.

Function
REQ-012 FSM states: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
REQ-013 IDLE, start=1: latch a, b, cin into internal registers; clear digit counter and partial sum; go to RUN.
REQ-014 RUN: each cycle add DIGIT bits of latched a and b at the counter position, plus the carry register; write the digit sum into the partial sum; update the carry; increment the counter.
REQ-015 RUN -> DONE on the edge that processes digit N-1; on that same edge, load s with {final carry, partial sum}.
REQ-016 Latency: start sampled at edge k -> done high in the cycle after edge k+N; busy high for exactly N cycles.
REQ-017 DONE lasts one cycle. DONE with start=1: latch new operands and go to RUN (back-to-back, no idle gap). DONE with start=0: go to IDLE.
REQ-018 start in RUN is ignored; latched operands stay unchanged; no queuing.
REQ-019 Changes on a, b or cin after the start edge do not affect the result.
REQ-020 s holds its last value until the next DONE-entry edge; s does not change in IDLE or RUN.
REQ-021 Arithmetic is unsigned modulo 2^(WIDTH+1); the result always equals a + b + cin exactly, with no truncation.
REQ-022 busy and done are registered outputs, decoded from state; they are never asserted together.

Reset
REQ-023 rst=1 forces state to IDLE immediately, without waiting for a clock edge.
REQ-024 rst=1 sets busy=0, done=0, s=0, and clears the counter, carry and partial sum.
REQ-025 Reset during RUN abandons the operation: no done pulse, and s reads 0.
REQ-026 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN, when defined, adds input port sub (1 bit, sampled with the operands).
REQ-028 With the macro defined and sub=1: compute a - b as a + ~b + 1; cin is ignored; s[WIDTH]=1 means no borrow. With sub=0, behaviour is as without the macro.
REQ-029 Without the macro: no sub port, and add-only behaviour is identical to REQ-013..REQ-022.

Verification
REQ-030 WIDTH=8, DIGIT=2: a=0xFF, b=0x01, cin=0, start pulse -> busy high for 4 cycles, then done for 1 cycle with s=0x100.
REQ-031 WIDTH=8, DIGIT=2: a=0x5A, b=0x3C, cin=1; start held high across RUN; a, b changed mid-RUN -> exactly one result, s=0x097, no extra operation.
REQ-032 Back-to-back: start=1 in the DONE cycle with a=0x80, b=0x80 -> busy the next cycle, then s=0x100; the previous s is held until then.
REQ-033 rst pulse asserted mid-RUN, between clock edges -> busy=0, done=0, s=0 immediately; no done pulse follows.
REQ-034 WIDTH=8, DIGIT=8: a=0xF0, b=0x0F, cin=1 -> single RUN cycle, s=0x100.
REQ-035 SERIAL_ADDER_SUB_EN defined, sub=1: a=0x05, b=0x07 -> s=0x0FE (borrow); a=0x07, b=0x05 -> s=0x102.
